tdm_demux_1x2: RTL and testbench
================================

# tdm_demux_1x2

Two-channel time-division demultiplexer. It is the receive end of the 2:1 selector path: it takes a single word stream whose words alternate between channel 0 and channel 1 and steers each word to its own registered output channel. Each channel has a one-entry buffer and a valid/ready handshake. A sync marker realigns the slot counter, and misalignment is reported. It sits downstream of the lab mux datapath, and its outputs feed the per-channel consumers.

## Interface
Parameters:
- W, 8, data word width in bits.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- din  in  W  multiplexed input word.
- din_valid  in  1  din holds a word.
- din_sync  in  1  qualifies din as the channel-0 word that starts a frame.
- din_ready  out  1  block accepts din this cycle (combinational).
- y0  out  W  channel-0 word (registered).
- v0  out  1  y0 valid.
- r0  in  1  channel-0 consumer ready.
- y1  out  W  channel-1 word (registered).
- v1  out  1  y1 valid.
- r1  in  1  channel-1 consumer ready.
- slot  out  1  channel the next non-sync word goes to.
- align_err  out  1  one-cycle pulse on a misaligned sync.
- err_cnt  out  8  misalignment count (see Configuration).

## Operation
- Accept: a word is accepted when din_valid && din_ready.
- Target channel: t = din_sync ? 0 : slot.
- din_ready = !v_t || r_t. This is the target channel's buffer state. Backpressure on the other channel never blocks.
- On accept:
  - y_t <= din and v_t <= 1.
  - slot <= ~t, so words alternate 0,1,0,1 and a sync always leaves slot = 1.
- Channel k buffer:
  - v_k clears on v_k && r_k.
  - If a drain and a load hit the same cycle, the load wins: v_k stays 1 and y_k takes the new word.
  - y_k is unchanged while v_k = 1 and no load occurs.
- Misalignment: an accepted word with din_sync = 1 while slot = 1 raises align_err for exactly the next cycle. The word still goes to channel 0, and slot resyncs to 1.
- Sync with slot = 0: this is normal and raises no error.
- A non-accepted word (din_ready = 0 or din_valid = 0) changes no state, including slot.
- Reset values: slot = 0, v0 = v1 = 0, y0 = y1 = 0, align_err = 0, err_cnt = 0.
- Reset mid-operation: buffered words are discarded immediately on rst_n low, with no drain.

## Timing
- Latency: 1 cycle. A word accepted at edge n appears on y_t with v_t = 1 after edge n.
- Throughput: one word per cycle when the target consumers hold r = 1.
- din_ready depends combinationally on din_sync, slot, v0/v1 and r0/r1. There is no path from din_valid to din_ready.
- align_err asserts the cycle after the offending accept and deasserts the following cycle. Back-to-back misaligned accepts give consecutive pulses.
- Outputs go to reset values asynchronously when rst_n falls. Release of rst_n is synchronized by the integrator.

## Configuration
- Macro: TDM_DEMUX_ERR_CNT_EN.
- Defined: err_cnt is an 8-bit counter. It increments on each align_err pulse and saturates at 255. It clears only on reset.
- Undefined: no counter is built and err_cnt is tied to 0. align_err is present in both builds.

## Test plan
- Aligned stream, r0 = r1 = 1: accept 0x11 (sync), 0x22, 0x33, 0x44 on four consecutive cycles.
  - Required: y0 = 0x11 then 0x33, and y1 = 0x22 then 0x44, each one cycle after accept.
  - din_ready stays 1 throughout; align_err stays 0; slot ends at 0.
- Per-channel backpressure, r1 = 0 with v1 = 1 holding 0xAA: present a channel-1 word 0xBB.
  - Required: din_ready = 0, slot, y1 and v1 unchanged.
  - With slot = 1 held by the stall, present 0xCC with din_sync = 1. It is accepted to y0 and raises align_err.
  - After r1 = 1 for one cycle, v1 clears.
- Misaligned sync: after accepting 0x01 (sync), accept 0x05 with din_sync = 1 while slot = 1.
  - Required: y0 = 0x05 and align_err = 1 for one cycle; slot = 1 afterwards.
  - err_cnt = 1 with the macro defined, 0 without.
- Simultaneous drain and load on channel 0: v0 = 1 holding 0x10, r0 = 1, accept 0x20 to channel 0.
  - Required: next cycle v0 = 1 and y0 = 0x20, with no dropped or duplicated word.
- Counter saturation, macro defined: 300 misaligned syncs.
  - Required: err_cnt = 255 and exactly 300 align_err pulses.
  - Macro undefined: err_cnt = 0 throughout.
- Asynchronous reset mid-stream: assert rst_n = 0 between edges while v0 = v1 = 1 and slot = 1.
  - Required: v0 = v1 = 0, y0 = y1 = 0 and slot = 0 immediately, before the next edge.
  - After release, the first non-sync word goes to channel 0.

Source files
------------

// File: rtl/tdm_demux_1x2.sv
// tdm_demux_1x2 -- two-channel time-division demultiplexer.
//
// Receives one word stream whose words alternate between channel 0 and
// channel 1, and steers each accepted word into a one-entry registered
// buffer per channel, each with its own valid/ready handshake.
//
// A word flagged with din_sync is always a channel-0 word and realigns the
// slot counter. A sync that arrives while the counter expects channel 1 is
// a misalignment. It still goes to channel 0, and it raises align_err for
// the following cycle.
//
// Build option: define TDM_DEMUX_ERR_CNT_EN to build an 8-bit saturating
// misalignment counter on err_cnt. Without it, err_cnt is tied to zero.
// align_err exists in both builds.

module tdm_demux_1x2 #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] din,
  input  logic         din_valid,
  input  logic         din_sync,
  output logic         din_ready,
  output logic [W-1:0] y0,
  output logic         v0,
  input  logic         r0,
  output logic [W-1:0] y1,
  output logic         v1,
  input  logic         r1,
  output logic         slot,
  output logic         align_err,
  output logic [7:0]   err_cnt
);

  // Slot counter: the channel that the next non-sync word goes to.
  logic slot_q;
  logic slot_d;

  // Misalignment pulse register.
  logic align_err_q;
  logic align_err_d;

  // Per-channel views, gathered so that the channel logic is written once.
  logic [1:0]   v_vec;
  logic [1:0]   r_vec;
  logic [1:0]   load_vec;
  logic [W-1:0] y_arr [2];

  // Target selection and acceptance.
  logic tgt;
  logic accept;
  logic misaligned;

  assign r_vec = {r1, r0};

  // A sync word always belongs to channel 0. Any other word follows the
  // slot counter. din_ready looks only at the target buffer, so a stalled
  // consumer on the other channel never blocks the stream. din_valid does
  // not feed din_ready.
  always_comb begin
    tgt        = 1'b0;
    din_ready  = 1'b0;
    accept     = 1'b0;
    misaligned = 1'b0;
    tgt        = din_sync ? 1'b0 : slot_q;
    din_ready  = !v_vec[tgt] || r_vec[tgt];
    accept     = din_valid && din_ready;
    misaligned = accept && din_sync && slot_q;
  end

  // The slot advances only on an accepted word. It always lands on the
  // opposite channel of the word just taken, so a sync leaves it at 1.
  // The error pulse is set for exactly the cycle after a misaligned accept.
  always_comb begin
    slot_d      = slot_q;
    align_err_d = misaligned;
    if (accept) begin
      slot_d = ~tgt;
    end
  end

  // Slot counter and error pulse registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_q      <= 1'b0;
      align_err_q <= 1'b0;
    end else begin
      slot_q      <= slot_d;
      align_err_q <= align_err_d;
    end
  end

  // One-entry output buffer per channel.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_ch
      logic         v_q;
      logic         v_d;
      logic [W-1:0] y_q;
      logic [W-1:0] y_d;
      logic         drain;

      assign load_vec[gi] = accept && (tgt == 1'(gi));
      assign drain        = v_q && r_vec[gi];

      // A load overrides a drain in the same cycle. The consumer takes the
      // old word at this edge, and the new word replaces it without a
      // bubble. With no load, y holds its word and only v can clear.
      always_comb begin
        v_d = v_q;
        y_d = y_q;
        if (load_vec[gi]) begin
          v_d = 1'b1;
          y_d = din;
        end else if (drain) begin
          v_d = 1'b0;
        end
      end

      // Buffer registers. Reset discards any held word at once.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          v_q <= 1'b0;
          y_q <= '0;
        end else begin
          v_q <= v_d;
          y_q <= y_d;
        end
      end

      assign v_vec[gi] = v_q;
      assign y_arr[gi] = y_q;
    end
  endgenerate

`ifdef TDM_DEMUX_ERR_CNT_EN
  // Count align_err pulses. The count saturates at 255 instead of
  // wrapping, so a large count cannot read as a small one.
  logic [7:0] err_cnt_q;
  logic [7:0] err_cnt_d;

  // Counter next state: increment on each pulse, hold at full scale.
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (align_err_q && (err_cnt_q != 8'hFF)) begin
      err_cnt_d = err_cnt_q + 8'd1;
    end
  end

  // Counter register. Only reset clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt_q <= 8'd0;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end

  assign err_cnt = err_cnt_q;
`else
  assign err_cnt = 8'd0;
`endif

  assign y0        = y_arr[0];
  assign v0        = v_vec[0];
  assign y1        = y_arr[1];
  assign v1        = v_vec[1];
  assign slot      = slot_q;
  assign align_err = align_err_q;

endmodule

// File: tb/tb_tdm_demux_1x2.sv
// Testbench for tdm_demux_1x2.
//
// The stimulus process drives directed words. It pushes the word each
// channel is expected to deliver into that channel's queue. A separate
// monitor pops a queue entry and compares it whenever a channel completes a
// v && r transfer. Expected err_cnt depends on TDM_DEMUX_ERR_CNT_EN.

module tb_tdm_demux_1x2;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [W-1:0] din = '0;
  logic         din_valid = 1'b0;
  logic         din_sync = 1'b0;
  logic         din_ready;
  logic [W-1:0] y0;
  logic         v0;
  logic         r0 = 1'b1;
  logic [W-1:0] y1;
  logic         v1;
  logic         r1 = 1'b1;
  logic         slot;
  logic         align_err;
  logic [7:0]   err_cnt;

  int checks = 0;
  int errors = 0;
  int pulses = 0;
  int errs_m = 0;
  bit slot_m = 1'b0;
  logic [W-1:0] q0 [$];
  logic [W-1:0] q1 [$];

  always #5 clk = ~clk;

  tdm_demux_1x2 #(.W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .din       (din),
    .din_valid (din_valid),
    .din_sync  (din_sync),
    .din_ready (din_ready),
    .y0        (y0),
    .v0        (v0),
    .r0        (r0),
    .y1        (y1),
    .v1        (v1),
    .r1        (r1),
    .slot      (slot),
    .align_err (align_err),
    .err_cnt   (err_cnt)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic int exp_cnt();
`ifdef TDM_DEMUX_ERR_CNT_EN
    return errs_m;
`else
    return 0;
`endif
  endfunction

  // Monitor: compare every completed channel transfer with the scoreboard.
  initial begin
    logic [W-1:0] e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (v0 && r0) begin
          if (q0.size() == 0) begin
            checks++; errors++;
            $display("FAIL ch0_word actual=%0h required=none", y0);
          end else begin
            e = q0.pop_front();
            chk("ch0_word", 32'(y0), 32'(e));
            $display("ch0 out %02h", y0);
          end
        end
        if (v1 && r1) begin
          if (q1.size() == 0) begin
            checks++; errors++;
            $display("FAIL ch1_word actual=%0h required=none", y1);
          end else begin
            e = q1.pop_front();
            chk("ch1_word", 32'(y1), 32'(e));
            $display("ch1 out %02h", y1);
          end
        end
        if (align_err) pulses++;
      end
    end
  end

  // Present one word that must be accepted. Update the model and check the
  // registered result one edge later.
  task automatic send(input logic [W-1:0] d, input bit s);
    bit t;
    bit e_err;
    din = d; din_sync = s; din_valid = 1'b1;
    @(negedge clk);
    chk("din_ready", 32'(din_ready), 32'd1);
    t = s ? 1'b0 : slot_m;
    if (t) q1.push_back(d); else q0.push_back(d);
    e_err = s && slot_m;
    if (e_err && errs_m < 255) errs_m++;
    slot_m = !t;
    @(posedge clk); #1;
    din_valid = 1'b0;
    $display("in %02h sync=%0d -> ch%0d", d, s, t);
    chk("align_err", 32'(align_err), 32'(e_err));
    chk("slot", 32'(slot), 32'(slot_m));
    if (t) begin
      chk("y1_load", 32'(y1), 32'(d));
      chk("v1_load", 32'(v1), 32'd1);
    end else begin
      chk("y0_load", 32'(y0), 32'(d));
      chk("v0_load", 32'(v0), 32'd1);
    end
  endtask

  task automatic idle();
    din_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    chk("rst_v0", 32'(v0), 0); chk("rst_v1", 32'(v1), 0);
    chk("rst_y0", 32'(y0), 0); chk("rst_y1", 32'(y1), 0);
    chk("rst_slot", 32'(slot), 0); chk("rst_align", 32'(align_err), 0);
    chk("rst_cnt", 32'(err_cnt), 0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Aligned stream.
    send(8'h11, 1); send(8'h22, 0); send(8'h33, 0); send(8'h44, 0);
    idle();
    chk("aligned_slot", 32'(slot), 0);

    // Per-channel backpressure.
    r1 = 1'b0;
    send(8'h5A, 0); send(8'hAA, 0); send(8'h5B, 0);
    din = 8'hBB; din_sync = 1'b0; din_valid = 1'b1;
    @(negedge clk);
    chk("bp_ready", 32'(din_ready), 0);
    @(posedge clk); #1;
    din_valid = 1'b0;
    $display("in bb sync=0 stalled");
    chk("bp_slot", 32'(slot), 1); chk("bp_y1", 32'(y1), 32'h0AA);
    chk("bp_v1", 32'(v1), 1);
    send(8'hCC, 1);
    r1 = 1'b1;
    idle();
    chk("bp_v1_clear", 32'(v1), 0);

    // Misaligned sync.
    send(8'h0E, 0); send(8'h01, 1); send(8'h05, 1);
    idle();
    chk("mis_align_low", 32'(align_err), 0);
    chk("mis_slot", 32'(slot), 1);
    chk("mis_cnt", 32'(err_cnt), 32'(exp_cnt()));

    // Simultaneous drain and load on channel 0.
    send(8'h0F, 0); send(8'h10, 0); send(8'h20, 1);

    // Counter saturation.
    idle(); idle();
    begin
      int base;
      base = pulses;
      for (int i = 0; i < 300; i++) send(8'(i), 1);
      idle(); idle();
      chk("sat_pulses", 32'(pulses - base), 300);
      chk("sat_cnt", 32'(err_cnt), 32'(exp_cnt()));
    end

    // Asynchronous reset mid-stream.
    send(8'h61, 0);
    r1 = 1'b0;
    send(8'h60, 0);
    r0 = 1'b0;
    chk("pre_rst_v0", 32'(v0), 1); chk("pre_rst_v1", 32'(v1), 1);
    chk("pre_rst_slot", 32'(slot), 1);
    #2 rst_n = 1'b0;
    #1;
    q0.delete(); q1.delete(); slot_m = 1'b0; errs_m = 0;
    chk("arst_v0", 32'(v0), 0); chk("arst_v1", 32'(v1), 0);
    chk("arst_y0", 32'(y0), 0); chk("arst_y1", 32'(y1), 0);
    chk("arst_slot", 32'(slot), 0); chk("arst_cnt", 32'(err_cnt), 0);
    @(posedge clk);
    @(negedge clk); rst_n = 1'b1; r0 = 1'b1; r1 = 1'b1;
    @(posedge clk); #1;
    send(8'h70, 0);
    idle(); idle();
    chk("q0_empty", 32'(q0.size()), 0);
    chk("q1_empty", 32'(q1.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
